// File: rtl/fmlt_pipe_unit.sv
// Purpose : pipelined binary32 multiplier (MUL, NMUL, SQR, AMUL) with RNE rounding, FTZ and
//           IEEE exception flags; Index/Issue_No tags ride along with each result.
// Latency : 3 cycles fixed, issue at edge N gives O_Valid after edge N+3; 1 op per cycle.
// Backpr. : global I_Stall freezes every stage and the outputs; no internal backpressure.
// Ports   : clock/reset (sync, active-high); I_En/I_Stall control; I_Op, I_Data1/2 operands;
//           I_Index/I_Issue_No tags in; O_Valid, O_Data, O_Index, O_Issue_No, O_Flags
//           {NV,OF,UF,NX} out, all forced to 0 when O_Valid=0.
module fmlt_pipe_unit #(
  parameter int WIDTH_DATA     = 32,
  parameter int WIDTH_OP       = 2,
  parameter int WIDTH_INDEX    = 7,
  parameter int WIDTH_ISSUE_NO = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      I_En,
  input  logic                      I_Stall,
  input  logic [WIDTH_OP-1:0]       I_Op,
  input  logic [WIDTH_DATA-1:0]     I_Data1,
  input  logic [WIDTH_DATA-1:0]     I_Data2,
  input  logic [WIDTH_INDEX-1:0]    I_Index,
  input  logic [WIDTH_ISSUE_NO-1:0] I_Issue_No,
  output logic                      O_Valid,
  output logic [WIDTH_DATA-1:0]     O_Data,
  output logic [WIDTH_INDEX-1:0]    O_Index,
  output logic [WIDTH_ISSUE_NO-1:0] O_Issue_No,
  output logic [3:0]                O_Flags
);

  localparam logic [WIDTH_OP-1:0] OP_NMUL = WIDTH_OP'(1);
  localparam logic [WIDTH_OP-1:0] OP_SQR  = WIDTH_OP'(2);
  localparam logic [WIDTH_OP-1:0] OP_AMUL = WIDTH_OP'(3);
  localparam logic [31:0]         QNAN    = 32'h7FC0_0000;

  // Result class resolved once in S1; only K_NORM uses the arithmetic path.
  typedef enum logic [1:0] {K_NORM = 2'd0, K_ZERO = 2'd1, K_INF = 2'd2, K_NAN = 2'd3} kind_t;

  // ---------------- S1: unpack / classify ----------------
  logic [31:0] w_b;
  logic [7:0]  w_ea, w_eb;
  logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_snan;
  logic        w_sign;
  kind_t       w_kind;
  logic        w_nv;

  assign w_b      = (I_Op == OP_SQR) ? I_Data1 : I_Data2;
  assign w_ea     = I_Data1[30:23];
  assign w_eb     = w_b[30:23];
  // exp==0 is zero regardless of mantissa: subnormal inputs are flushed.
  assign w_a_zero = (w_ea == 8'h00);
  assign w_b_zero = (w_eb == 8'h00);
  assign w_a_inf  = (w_ea == 8'hFF) && (I_Data1[22:0] == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_b[22:0] == 23'd0);
  assign w_a_nan  = (w_ea == 8'hFF) && (I_Data1[22:0] != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_b[22:0] != 23'd0);
  assign w_snan   = (w_a_nan && !I_Data1[22]) || (w_b_nan && !w_b[22]);

  // Sign mode folded in early; NaN results ignore the sign at pack time anyway.
  always_comb begin
    w_sign = I_Data1[31] ^ w_b[31];
    if (I_Op == OP_NMUL)      w_sign = ~w_sign;
    else if (I_Op == OP_AMUL) w_sign = 1'b0;
  end

  always_comb begin
    w_kind = K_NORM;
    w_nv   = 1'b0;
    if (w_a_nan || w_b_nan) begin
      w_kind = K_NAN;
      w_nv   = w_snan;
    end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_kind = K_NAN;
      w_nv   = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      w_kind = K_INF;
    end else if (w_a_zero || w_b_zero) begin
      w_kind = K_ZERO;
    end
  end

  logic                      r_s1_vld, r_s1_sign, r_s1_nv;
  logic [WIDTH_INDEX-1:0]    r_s1_idx;
  logic [WIDTH_ISSUE_NO-1:0] r_s1_iss;
  kind_t                     r_s1_kind;
  logic [7:0]                r_s1_ea, r_s1_eb;
  logic [23:0]               r_s1_ma, r_s1_mb;

  // ---------------- S2: multiply, exponent sum ----------------
  logic [47:0]        w_s2_prod;
  logic signed [9:0]  w_s2_exp;

  assign w_s2_prod = {24'd0, r_s1_ma} * {24'd0, r_s1_mb};
  assign w_s2_exp  = $signed({2'b00, r_s1_ea}) + $signed({2'b00, r_s1_eb}) - 10'sd127;

  logic                      r_s2_vld, r_s2_sign, r_s2_nv;
  logic [WIDTH_INDEX-1:0]    r_s2_idx;
  logic [WIDTH_ISSUE_NO-1:0] r_s2_iss;
  kind_t                     r_s2_kind;
  logic [47:0]               r_s2_prod;
  logic signed [9:0]         r_s2_exp;

  // ---------------- S3: normalise, extract guard/sticky ----------------
  // Product of two [1,2) mantissas lies in [1,4): bit47 decides the 1-bit right shift.
  // The leading one is implied from here on, so only the 23 fraction bits are kept.
  logic              w_s3_hi;
  logic [22:0]       w_s3_frac;
  logic              w_s3_guard, w_s3_sticky;
  logic signed [9:0] w_s3_exp;

  assign w_s3_hi     = r_s2_prod[47];
  assign w_s3_frac   = w_s3_hi ? r_s2_prod[46:24] : r_s2_prod[45:23];
  assign w_s3_guard  = w_s3_hi ? r_s2_prod[23]    : r_s2_prod[22];
  assign w_s3_sticky = w_s3_hi ? |r_s2_prod[22:0] : |r_s2_prod[21:0];
  assign w_s3_exp    = r_s2_exp + (w_s3_hi ? 10'sd1 : 10'sd0);

  logic                      r_s3_vld, r_s3_sign, r_s3_nv;
  logic [WIDTH_INDEX-1:0]    r_s3_idx;
  logic [WIDTH_ISSUE_NO-1:0] r_s3_iss;
  kind_t                     r_s3_kind;
  logic [22:0]               r_s3_frac;
  logic                      r_s3_guard, r_s3_sticky;
  logic signed [9:0]         r_s3_exp;

  // ---------------- Output: round, range check, pack ----------------
  logic              w_rnd_inc, w_rnd_carry, w_inexact;
  logic [22:0]       w_rnd_frac;
  logic signed [9:0] w_rnd_exp;
  logic [31:0]       w_res_data;
  logic [3:0]        w_res_flags;

  assign w_rnd_inc   = r_s3_guard & (r_s3_sticky | r_s3_frac[0]);
  // An all-ones fraction that rounds up wraps to 0 and bumps the exponent (1.11..1 -> 10.0).
  assign w_rnd_carry = w_rnd_inc & (&r_s3_frac);
  assign w_rnd_frac  = r_s3_frac + {22'd0, w_rnd_inc};
  assign w_rnd_exp   = r_s3_exp + (w_rnd_carry ? 10'sd1 : 10'sd0);
  assign w_inexact   = r_s3_guard | r_s3_sticky;

  always_comb begin
    w_res_data  = 32'd0;
    w_res_flags = 4'd0;
    case (r_s3_kind)
      K_NAN: begin
        w_res_data  = QNAN;
        w_res_flags = {r_s3_nv, 3'b000};
      end
      K_INF:  w_res_data = {r_s3_sign, 8'hFF, 23'd0};
      K_ZERO: w_res_data = {r_s3_sign, 31'd0};
      default: begin
        if (w_rnd_exp >= 10'sd255) begin
          w_res_data  = {r_s3_sign, 8'hFF, 23'd0};
          w_res_flags = 4'b0101;
        end else if (w_rnd_exp <= 10'sd0) begin
          // No subnormal outputs: anything below the normal range flushes to signed zero.
          w_res_data  = {r_s3_sign, 31'd0};
          w_res_flags = 4'b0011;
        end else begin
          w_res_data  = {r_s3_sign, w_rnd_exp[7:0], w_rnd_frac};
          w_res_flags = {3'b000, w_inexact};
        end
      end
    endcase
  end

  // ---------------- Pipeline registers ----------------
  // Reset wins over stall; stall freezes everything including outputs.
  // Tags are zeroed in bubbles so downstream never sees stale tags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_vld <= 1'b0; r_s1_sign <= 1'b0; r_s1_nv <= 1'b0; r_s1_kind <= K_NORM;
      r_s1_idx <= '0;   r_s1_iss  <= '0;   r_s1_ea <= '0;   r_s1_eb   <= '0;
      r_s1_ma  <= '0;   r_s1_mb   <= '0;
      r_s2_vld <= 1'b0; r_s2_sign <= 1'b0; r_s2_nv <= 1'b0; r_s2_kind <= K_NORM;
      r_s2_idx <= '0;   r_s2_iss  <= '0;   r_s2_prod <= '0; r_s2_exp  <= '0;
      r_s3_vld <= 1'b0; r_s3_sign <= 1'b0; r_s3_nv <= 1'b0; r_s3_kind <= K_NORM;
      r_s3_idx <= '0;   r_s3_iss  <= '0;   r_s3_frac <= '0; r_s3_exp  <= '0;
      r_s3_guard <= 1'b0; r_s3_sticky <= 1'b0;
      O_Valid  <= 1'b0; O_Data <= '0; O_Index <= '0; O_Issue_No <= '0; O_Flags <= '0;
    end else if (!I_Stall) begin
      r_s1_vld  <= I_En;
      r_s1_idx  <= I_En ? I_Index : '0;
      r_s1_iss  <= I_En ? I_Issue_No : '0;
      r_s1_sign <= w_sign;
      r_s1_nv   <= w_nv;
      r_s1_kind <= w_kind;
      r_s1_ea   <= w_ea;
      r_s1_eb   <= w_eb;
      r_s1_ma   <= {1'b1, I_Data1[22:0]};
      r_s1_mb   <= {1'b1, w_b[22:0]};

      r_s2_vld  <= r_s1_vld;
      r_s2_idx  <= r_s1_idx;
      r_s2_iss  <= r_s1_iss;
      r_s2_sign <= r_s1_sign;
      r_s2_nv   <= r_s1_nv;
      r_s2_kind <= r_s1_kind;
      r_s2_prod <= w_s2_prod;
      r_s2_exp  <= w_s2_exp;

      r_s3_vld    <= r_s2_vld;
      r_s3_idx    <= r_s2_idx;
      r_s3_iss    <= r_s2_iss;
      r_s3_sign   <= r_s2_sign;
      r_s3_nv     <= r_s2_nv;
      r_s3_kind   <= r_s2_kind;
      r_s3_frac   <= w_s3_frac;
      r_s3_guard  <= w_s3_guard;
      r_s3_sticky <= w_s3_sticky;
      r_s3_exp    <= w_s3_exp;

      O_Valid    <= r_s3_vld;
      O_Data     <= r_s3_vld ? w_res_data : '0;
      O_Flags    <= r_s3_vld ? w_res_flags : '0;
      O_Index    <= r_s3_idx;
      O_Issue_No <= r_s3_iss;
    end
  end

endmodule

// File: tb/tb_fmlt_pipe_unit.sv
// Bench for fmlt_pipe_unit: directed corner values, back-to-back issue with stalls,
// random traffic against an arithmetic reference model, and reset with ops in flight.
module tb_fmlt_pipe_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        I_En, I_Stall;
  logic [1:0]  I_Op;
  logic [31:0] I_Data1, I_Data2;
  logic [6:0]  I_Index;
  logic [4:0]  I_Issue_No;
  logic        O_Valid;
  logic [31:0] O_Data;
  logic [6:0]  O_Index;
  logic [4:0]  O_Issue_No;
  logic [3:0]  O_Flags;

  int checks = 0;
  int errors = 0;

  fmlt_pipe_unit dut (
    .clock(clock), .reset(reset), .I_En(I_En), .I_Stall(I_Stall), .I_Op(I_Op),
    .I_Data1(I_Data1), .I_Data2(I_Data2), .I_Index(I_Index), .I_Issue_No(I_Issue_No),
    .O_Valid(O_Valid), .O_Data(O_Data), .O_Index(O_Index), .O_Issue_No(O_Issue_No),
    .O_Flags(O_Flags)
  );

  always #5 clock = ~clock;

  // Observed output bundle: {valid, data, flags, index, issue_no}
  logic [48:0] obs_vec;
  assign obs_vec = {O_Valid, O_Data, O_Flags, O_Index, O_Issue_No};

  // Expected-result queue: each accepted op is due 3 unstalled edges after acceptance.
  typedef struct {
    int          due;
    logic [48:0] vec;
  } exp_t;
  exp_t        exp_q[$];
  int          adv = 0;
  logic [48:0] exp_vec = '0;

  // Reference: exact integer product, then quotient/remainder rounding to 24 bits.
  function automatic logic [35:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b_in);
    logic [31:0] b, r;
    logic [3:0]  f;
    int          ea, eb, e, shift;
    longint unsigned ma, mb, p, q, rem, half;
    bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, snan, sgn;
    b      = (op == 2'd2) ? a : b_in;
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    snan   = (a_nan && !a[22]) || (b_nan && !b[22]);
    sgn    = a[31] ^ b[31];
    if (op == 2'd1) sgn = !sgn;
    else if (op == 2'd3) sgn = 1'b0;
    f = 4'd0;
    if (a_nan || b_nan) begin
      r = 32'h7FC00000; f[3] = snan;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      r = 32'h7FC00000; f = 4'b1000;
    end else if (a_inf || b_inf) begin
      r = {sgn, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      r = {sgn, 31'd0};
    end else begin
      ma    = 64'h800000 | 64'(a[22:0]);
      mb    = 64'h800000 | 64'(b[22:0]);
      p     = ma * mb;
      shift = (p >= 64'h8000_0000_0000) ? 24 : 23;
      e     = ea + eb - 127 + (shift - 23);
      q     = p >> shift;
      rem   = p - (q << shift);
      half  = 64'd1 << (shift - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == 64'h1000000) begin q = 64'h800000; e = e + 1; end
      if (e >= 255) begin
        r = {sgn, 8'hFF, 23'd0}; f = 4'b0101;
      end else if (e <= 0) begin
        r = {sgn, 31'd0}; f = 4'b0011;
      end else begin
        r = {sgn, 8'(e), q[22:0]}; f = {3'b000, rem != 0};
      end
    end
    return {r, f};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 7))
      0:       e = 8'd0;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 20));
      3:       e = 8'($urandom_range(235, 254));
      4, 5:    e = 8'($urandom_range(100, 154));
      default: e = 8'($urandom_range(0, 255));
    endcase
    case ($urandom_range(0, 7))
      0, 1:    m = 23'd0;
      2:       m = 23'h400000;
      3:       m = 23'h7FFFFF;
      default: m = 23'($urandom);
    endcase
    return {1'($urandom), e, m};
  endfunction

  // Drive one cycle of inputs, advance one edge, update the model's expected outputs.
  task automatic tick(input logic en, input logic stall, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [6:0] idx, input logic [4:0] iss);
    logic [35:0] rf;
    exp_t        ent;
    I_En = en; I_Stall = stall; I_Op = op; I_Data1 = a; I_Data2 = b;
    I_Index = idx; I_Issue_No = iss;
    @(posedge clock); #1;
    if (!stall) begin
      adv++;
      if (exp_q.size() > 0 && exp_q[0].due == adv) begin
        exp_vec = exp_q[0].vec;
        void'(exp_q.pop_front());
      end else begin
        exp_vec = '0;
      end
      if (en) begin
        rf      = ref_mul(op, a, b);
        ent.due = adv + 3;
        ent.vec = {1'b1, rf[35:4], rf[3:0], idx, iss};
        exp_q.push_back(ent);
      end
    end
  endtask

  task automatic bubble();
    tick(1'b0, 1'b0, 2'($urandom), $urandom, $urandom, 7'($urandom), 5'($urandom));
  endtask

  task automatic test_reset();
    reset = 1'b1; I_En = 1'b1; I_Stall = 1'b1; I_Op = 2'd0;
    I_Data1 = 32'h3F800000; I_Data2 = 32'h40000000; I_Index = 7'd5; I_Issue_No = 5'd3;
    repeat (2) @(posedge clock);
    #1;
    exp_q.delete(); exp_vec = '0;
    checks++;
    if (obs_vec !== 49'd0) begin
      errors++; $display("FAIL reset_state: got %h required 0", obs_vec);
    end
    reset = 1'b0;
  endtask

  logic [1:0]  d_op [17] = '{2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd0,
                             2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
  logic [31:0] d_a  [17] = '{32'h40000000, 32'h3F800800, 32'h7F000000, 32'h7F800000,
                             32'h3F800000, 32'hBF800000, 32'h7F800001, 32'hFFC00000,
                             32'h00800000, 32'h80000001, 32'hFF800000, 32'hFF800000,
                             32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'h00800000,
                             32'h00800000};
  logic [31:0] d_b  [17] = '{32'h40400000, 32'h7F800001, 32'h7F000000, 32'h00000000,
                             32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F800000,
                             32'h00800000, 32'h3F800000, 32'h40000000, 32'h40000000,
                             32'h3FFFFFFE, 32'h3F800000, 32'h80000000, 32'h3F800000,
                             32'h3F000000};
  // 3F800800^2 = 1+2^-11+2^-24: the 2^-24 term is an exact half-ulp tie, LSB even -> down.
  // 3F800001*3FFFFFFE rounds up through an all-ones mantissa into 2.0.
  logic [31:0] d_r  [17] = '{32'h40C00000, 32'h3F801000, 32'h7F800000, 32'h7FC00000,
                             32'hC0000000, 32'h40000000, 32'h7FC00000, 32'h7FC00000,
                             32'h00000000, 32'h80000000, 32'hFF800000, 32'h7F800000,
                             32'h40000000, 32'h7F7FFFFF, 32'h7FC00000, 32'h00800000,
                             32'h00000000};
  logic [3:0]  d_f  [17] = '{4'h0, 4'h1, 4'h5, 4'h8, 4'h0, 4'h0, 4'h8, 4'h0, 4'h3,
                             4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h8, 4'h0, 4'h3};

  task automatic test_directed();
    logic [48:0] want;
    for (int i = 0; i < 17; i++) begin
      tick(1'b1, 1'b0, d_op[i], d_a[i], d_b[i], 7'(i + 1), 5'(i));
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL directed_issue[%0d]: got %h required %h", i, obs_vec, exp_vec);
      end
      for (int k = 0; k < 3; k++) begin
        bubble();
        checks++;
        if (obs_vec !== exp_vec) begin
          errors++; $display("FAIL directed_pipe[%0d]: got %h required %h", i, obs_vec, exp_vec);
        end
      end
      want = {1'b1, d_r[i], d_f[i], 7'(i + 1), 5'(i)};
      checks++;
      if (obs_vec !== want) begin
        errors++; $display("FAIL directed_value[%0d]: got %h required %h", i, obs_vec, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    // I=issue next index, S=stall (with junk on the inputs), B=bubble
    string plan = "IIISSIBSSBBBBB";
    int    seen[$];
    int    next_idx = 1;
    int    got;
    logic  st;
    for (int i = 0; i < plan.len(); i++) begin
      st = (plan[i] == "S");
      if (plan[i] == "I") begin
        tick(1'b1, 1'b0, 2'($urandom), rand_operand(), rand_operand(), 7'(next_idx), 5'(next_idx + 10));
        next_idx++;
      end else if (st) begin
        tick(1'b1, 1'b1, 2'd0, 32'h40000000, 32'h40000000, 7'd99, 5'd31);
      end else begin
        bubble();
      end
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL back_to_back cycle %0d: got %h required %h", i, obs_vec, exp_vec);
      end
      if (!st && O_Valid) seen.push_back(int'(O_Index));
    end
    checks++;
    if (seen.size() != 4) begin
      errors++; $display("FAIL back_to_back_count: got %0d results required 4", seen.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < seen.size()) ? seen[i] : -1;
      checks++;
      if (got != i + 1) begin
        errors++; $display("FAIL back_to_back_order[%0d]: got index %0d required %0d", i, got, i + 1);
      end
    end
  endtask

  task automatic test_random();
    logic en, st;
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) < 7);
      st = ($urandom_range(0, 9) < 2);
      tick(en, st, 2'($urandom), rand_operand(), rand_operand(), 7'($urandom), 5'($urandom));
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL random cycle %0d: got %h required %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reset_inflight();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 2'd0, 32'h40000000, 32'h40400000, 7'(40 + i), 5'(i + 1));
    end
    // Reset must win over a simultaneous stall and a new valid input.
    reset = 1'b1; I_Stall = 1'b1; I_En = 1'b1;
    @(posedge clock); #1;
    exp_q.delete(); exp_vec = '0;
    checks++;
    if (obs_vec !== 49'd0) begin
      errors++; $display("FAIL reset_inflight: got %h required 0", obs_vec);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bubble();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL reset_no_stale cycle %0d: got %h required %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
